// File: rtl/acc_display.sv
// rtl/acc_display.sv - 6-bit value to two BCD digits via double-dabble, driving a 2-digit muxed 7-seg display
module acc_display #(
   parameter int REFRESH_DIV = 50000,
   parameter bit ACTIVE_LOW  = 1'b1,
   parameter bit BLANK_LZ    = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] value,
   input  logic       load,
   output logic       busy,
   output logic       done,
   output logic [3:0] tens,
   output logic [3:0] ones,
   output logic [6:0] seg,
   output logic [1:0] an
);

   localparam int            CW      = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
   localparam logic          ST_IDLE = 1'b0;
   localparam logic          ST_CONV = 1'b1;
   localparam logic [6:0]    SEG_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;
   localparam logic [1:0]    AN_OFF  = ACTIVE_LOW ? 2'b11 : 2'b00;

   logic          state;
   logic [5:0]    shreg;
   logic [7:0]    scratch;
   logic [2:0]    step;
   logic [7:0]    adj;
   logic [7:0]    nxt_scratch;
   logic [CW-1:0] cnt;
   logic          sel;
   logic [3:0]    disp_digit;
   logic [6:0]    pat;
   logic [1:0]    an_raw;

   function automatic logic [6:0] seg_pattern(input logic [3:0] d);
      logic [6:0] p;
      case (d)
         4'd0:    p = 7'h3F;
         4'd1:    p = 7'h06;
         4'd2:    p = 7'h5B;
         4'd3:    p = 7'h4F;
         4'd4:    p = 7'h66;
         4'd5:    p = 7'h6D;
         4'd6:    p = 7'h7D;
         4'd7:    p = 7'h07;
         4'd8:    p = 7'h7F;
         4'd9:    p = 7'h6F;
         default: p = 7'h00;
      endcase
      return p;
   endfunction

   // One double-dabble step: correct nibbles >= 5, then shift in the next binary bit.
   always_comb begin
      adj[7:4]    = (scratch[7:4] >= 4'd5) ? scratch[7:4] + 4'd3 : scratch[7:4];
      adj[3:0]    = (scratch[3:0] >= 4'd5) ? scratch[3:0] + 4'd3 : scratch[3:0];
      nxt_scratch = {adj[6:0], shreg[5]};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         tens    <= 4'd0;
         ones    <= 4'd0;
         shreg   <= 6'd0;
         scratch <= 8'd0;
         step    <= 3'd0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (load) begin
                  shreg   <= value;
                  scratch <= 8'd0;
                  step    <= 3'd0;
                  busy    <= 1'b1;
                  state   <= ST_CONV;
               end
            end
            ST_CONV: begin
               scratch <= nxt_scratch;
               shreg   <= {shreg[4:0], 1'b0};
               step    <= step + 3'd1;
               if (step == 3'd5) begin
                  tens  <= nxt_scratch[7:4];
                  ones  <= nxt_scratch[3:0];
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
         sel <= 1'b0;
      end else if (cnt == CNT_MAX) begin
         cnt <= '0;
         sel <= ~sel;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   // sel=0 scans the ones digit, sel=1 the tens digit.
   always_comb begin
      disp_digit = sel ? tens : ones;
      pat        = seg_pattern(disp_digit);
      if (sel && BLANK_LZ && (tens == 4'd0))
         pat = 7'h00;
      an_raw     = sel ? 2'b10 : 2'b01;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         seg <= SEG_OFF;
         an  <= AN_OFF;
      end else begin
         seg <= ACTIVE_LOW ? ~pat : pat;
         an  <= ACTIVE_LOW ? ~an_raw : an_raw;
      end
   end

endmodule

// File: tb/tb_acc_display.sv
// tb/tb_acc_display.sv - self-checking bench for acc_display with a cycle model and directed vectors
module tb_acc_display;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       load = 1'b0;
   logic [5:0] value = 6'd0;

   logic       busy0, done0, busy1, done1;
   logic [3:0] tens0, ones0, tens1, ones1;
   logic [6:0] seg0, seg1;
   logic [1:0] an0, an1;

   acc_display #(.REFRESH_DIV(4), .ACTIVE_LOW(1'b1), .BLANK_LZ(1'b1)) u0 (
      .clk(clk), .rst(rst), .value(value), .load(load), .busy(busy0), .done(done0),
      .tens(tens0), .ones(ones0), .seg(seg0), .an(an0));

   acc_display #(.REFRESH_DIV(3), .ACTIVE_LOW(1'b0), .BLANK_LZ(1'b0)) u1 (
      .clk(clk), .rst(rst), .value(value), .load(load), .busy(busy1), .done(done1),
      .tens(tens1), .ones(ones1), .seg(seg1), .an(an1));

   always #5 clk = ~clk;

   localparam logic [6:0] PAT [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [6:0] exp_seg(input bit s, input int t, input int o, input bit al, input bit blz);
      logic [6:0] p;
      int d;
      d = s ? t : o;
      p = (d <= 9) ? PAT[d] : 7'h00;
      if (s && blz && t == 0) p = 7'h00;
      return al ? ~p : p;
   endfunction

   function automatic logic [1:0] exp_an(input bit s, input bit al);
      logic [1:0] a;
      a = s ? 2'b10 : 2'b01;
      return al ? ~a : a;
   endfunction

   // Model: conversion finishes 6 edges after load, digits by division; scan slot from edge count.
   bit         m_valid = 0;
   int         m_t, m_rem, m_cap, m_tens, m_ones;
   bit         m_busy, m_done;
   logic [6:0] m_seg0, m_seg1;
   logic [1:0] m_an0, m_an1;

   always @(posedge clk) begin
      if (rst) begin
         m_valid = 1;
         m_t = 0; m_rem = 0; m_tens = 0; m_ones = 0;
         m_busy = 0; m_done = 0;
         m_seg0 = 7'h7F; m_an0 = 2'b11;
         m_seg1 = 7'h00; m_an1 = 2'b00;
      end else if (m_valid) begin
         m_seg0 = exp_seg(((m_t / 4) % 2) == 1, m_tens, m_ones, 1'b1, 1'b1);
         m_an0  = exp_an(((m_t / 4) % 2) == 1, 1'b1);
         m_seg1 = exp_seg(((m_t / 3) % 2) == 1, m_tens, m_ones, 1'b0, 1'b0);
         m_an1  = exp_an(((m_t / 3) % 2) == 1, 1'b0);
         m_t++;
         m_done = 0;
         if (m_busy) begin
            m_rem--;
            if (m_rem == 0) begin
               m_tens = m_cap / 10;
               m_ones = m_cap % 10;
               m_busy = 0;
               m_done = 1;
            end
         end else if (load) begin
            m_cap  = value;
            m_busy = 1;
            m_rem  = 6;
         end
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         chk("busy0", busy0, m_busy);
         chk("done0", done0, m_done);
         chk("tens0", tens0, m_tens);
         chk("ones0", ones0, m_ones);
         chk("seg0", seg0, m_seg0);
         chk("an0", an0, m_an0);
         chk("busy1", busy1, m_busy);
         chk("done1", done1, m_done);
         chk("tens1", tens1, m_tens);
         chk("ones1", ones1, m_ones);
         chk("seg1", seg1, m_seg1);
         chk("an1", an1, m_an1);
      end
   end

   int cyc = 0, done_cnt = 0, last_cyc = 0, last_gap = 0;
   always @(posedge clk) begin
      if (done0) begin
         if (done_cnt > 0) last_gap = cyc - last_cyc;
         last_cyc = cyc;
         done_cnt++;
      end
      cyc++;
   end

   task automatic do_load(input logic [5:0] v);
      value = v;
      load  = 1'b1;
      @(negedge clk);
      load  = 1'b0;
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (!done0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("done_seen", done0, 1'b1);
   endtask

   task automatic wait_an(input logic [1:0] target);
      int n;
      n = 0;
      @(negedge clk);
      while (an0 !== target && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("an_seen", an0, target);
   endtask

   initial begin
      int n, d0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_seg", seg0, 7'h7F);
      chk("rst_an", an0, 2'b11);
      chk("rst_busy", busy0, 1'b0);
      rst = 1'b0;

      // 1: value 45
      do_load(6'd45);
      chk("t1_busy", busy0, 1'b1);
      wait_done(n);
      chk("t1_latency", n, 6);
      chk("t1_tens", tens0, 4);
      chk("t1_ones", ones0, 5);
      @(negedge clk);
      chk("t1_done_once", done0, 1'b0);
      wait_an(2'b10);
      chk("t1_seg_ones", seg0, 7'h12);
      wait_an(2'b01);
      chk("t1_seg_tens", seg0, 7'h19);

      // 2: 63 then back-to-back 0 in the done cycle
      do_load(6'd63);
      wait_done(n);
      chk("t2_tens", tens0, 6);
      chk("t2_ones", ones0, 3);
      do_load(6'd0);
      wait_done(n);
      repeat (2) @(negedge clk);
      chk("t2_gap", last_gap, 7);
      chk("t2_zero", {tens0, ones0}, 8'h00);
      wait_an(2'b01);
      chk("t2_blank", seg0, 7'h7F);

      // 3: load while busy ignored
      d0 = done_cnt;
      do_load(6'd9);
      repeat (2) @(negedge clk);
      do_load(6'd50);
      wait_done(n);
      chk("t3_tens", tens0, 0);
      chk("t3_ones", ones0, 9);
      repeat (10) @(negedge clk);
      chk("t3_one_done", done_cnt - d0, 1);

      // 4: digits 2/7, display stable while converting
      do_load(6'd27);
      wait_done(n);
      wait_an(2'b10);
      chk("t4_seg7", seg0, 7'h78);
      wait_an(2'b01);
      chk("t4_seg2", seg0, 7'h24);
      do_load(6'd27);
      wait_an(2'b10);
      chk("t4_busy_seg7", seg0, 7'h78);
      wait_done(n);

      // 5: reset mid-conversion, then rst+load together
      repeat (2) @(negedge clk);
      do_load(6'd37);
      repeat (2) @(negedge clk);
      d0 = done_cnt;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("t5_busy", busy0, 1'b0);
      chk("t5_digits", {tens0, ones0}, 8'h00);
      chk("t5_seg_off", seg0, 7'h7F);
      chk("t5_an_off", an0, 2'b11);
      @(negedge clk);
      chk("t5_an_ones", an0, 2'b10);
      chk("t5_seg_zero", seg0, 7'h40);
      repeat (10) @(negedge clk);
      chk("t5_no_done", done_cnt, d0);
      rst = 1'b1; value = 6'd5; load = 1'b1;
      @(negedge clk);
      rst = 1'b0; load = 1'b0;
      chk("t5_rst_wins", busy0, 1'b0);

      // 6: full sweep
      for (int v = 0; v < 64; v++) begin
         do_load(6'(v));
         wait_done(n);
         chk("t6_sweep", tens0 * 10 + ones0, v);
      end

      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
